// File: rtl/coherence_bus_ctrl_if.sv
// Bundle of core-side, snoop and RAM signals around the coherence controller.
// Handshake: a requester holds its request (iREN/dREN/dWEN/cctrans) and
// address/data stable while its wait bit is 1; a word completes in the cycle
// its wait bit reads 0, which is exactly the cycle RAM reports ACCESS.
interface coherence_bus_ctrl_if;
    logic [1:0]  iREN;
    logic [63:0] iaddr;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic [1:0]  dREN;
    logic [1:0]  dWEN;
    logic [63:0] daddr;
    logic [63:0] dstore;
    logic [1:0]  cctrans;
    logic [1:0]  ccwrite;
    logic [1:0]  dwait;
    logic [63:0] dload;
    logic [1:0]  ccwait;
    logic [1:0]  ccinv;
    logic [63:0] ccsnoopaddr;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [2:0]  dbg_state;
    logic        dbg_rr;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
               ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore, dbg_state, dbg_rr
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
               ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore, dbg_state, dbg_rr
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core coherence/memory controller: arbitrates the single-ported RAM,
// sequences snoops and performs dirty cache-to-cache transfers with writeback.
module coherence_bus_ctrl #(
    parameter int SNOOP_LAT = 2,
    parameter int BLK_WORDS = 2
) (
    input logic                  CLK,
    input logic                  RST,
    coherence_bus_ctrl_if.master bus
);
    localparam int WC_W = $clog2(BLK_WORDS + 1);
    localparam int SC_W = $clog2(SNOOP_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        SNOOP  = 3'd2,
        C2C    = 3'd3,
        LOAD   = 3'd4,
        IFETCH = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic            rr, rr_nx;
    logic            g, g_nx;
    logic [31:0]     base, base_nx;
    logic [WC_W-1:0] wcnt, wcnt_nx;
    logic [SC_W-1:0] scnt, scnt_nx;

    logic            o;
    logic            access;
    logic            last_word;
    logic [1:0]      wb_pick, sn_pick, if_pick;
    logic            gsel;
    logic [31:0]     gsel_daddr;

    // Select core c's 32-bit lane from a packed two-core bus.
    function automatic logic [31:0] lane(input logic [63:0] v, input logic c);
        return c ? v[63:32] : v[31:0];
    endfunction

    // Place a word into core c's lane, other lane zero.
    function automatic logic [63:0] put(input logic [31:0] w, input logic c);
        return c ? {w, 32'd0} : {32'd0, w};
    endfunction

    // Round-robin pick within one request class: {valid, core}.
    function automatic logic [1:0] pick(input logic [1:0] req, input logic r);
        if (req[r])       return {1'b1, r};
        else if (req[~r]) return {1'b1, ~r};
        else              return 2'b00;
    endfunction

    assign o          = ~g;
    assign access     = (bus.ramstate == 2'b10);
    assign last_word  = (wcnt == WC_W'(BLK_WORDS - 1));
    // Writebacks outrank coherence requests, which outrank instruction fetches.
    assign wb_pick    = pick(bus.dWEN & ~bus.cctrans, rr);
    assign sn_pick    = pick(bus.cctrans & ~bus.dWEN, rr);
    assign if_pick    = pick(bus.iREN, rr);
    assign gsel       = wb_pick[1] ? wb_pick[0] :
                        sn_pick[1] ? sn_pick[0] : if_pick[0];
    assign gsel_daddr = lane(bus.daddr, gsel);
    assign bus.dbg_state = state;
    assign bus.dbg_rr    = rr;

    // State and transaction-context registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            rr    <= 1'b0;
            g     <= 1'b0;
            base  <= 32'd0;
            wcnt  <= '0;
            scnt  <= '0;
        end else begin
            state <= state_nx;
            rr    <= rr_nx;
            g     <= g_nx;
            base  <= base_nx;
            wcnt  <= wcnt_nx;
            scnt  <= scnt_nx;
        end
    end

    // Next-state and all bus outputs; BUSY/ERROR simply keeps the current state.
    always_comb begin
        state_nx        = state;
        rr_nx           = rr;
        g_nx            = g;
        base_nx         = base;
        wcnt_nx         = wcnt;
        scnt_nx         = scnt;
        bus.iwait       = 2'b11;
        bus.dwait       = 2'b11;
        bus.iload       = 64'd0;
        bus.dload       = 64'd0;
        bus.ccwait      = 2'b00;
        bus.ccinv       = 2'b00;
        bus.ccsnoopaddr = 64'd0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = 32'd0;
        bus.ramstore    = 32'd0;

        case (state)
            IDLE: begin
                wcnt_nx = '0;
                scnt_nx = '0;
                if (wb_pick[1] || sn_pick[1] || if_pick[1]) begin
                    state_nx = wb_pick[1] ? WB : (sn_pick[1] ? SNOOP : IFETCH);
                    g_nx     = gsel;
                    rr_nx    = ~gsel;
                    base_nx  = gsel_daddr & 32'hFFFF_FFF8;
                end
            end
            WB: begin
                bus.ramWEN   = bus.dWEN[g];
                bus.ramaddr  = lane(bus.daddr, g);
                bus.ramstore = lane(bus.dstore, g);
                bus.dwait[g] = ~access;
            end
            SNOOP: begin
                bus.ccwait[o]   = 1'b1;
                bus.ccinv[o]    = bus.ccwrite[g];
                bus.ccsnoopaddr = put(base, o);
                if (scnt == SC_W'(SNOOP_LAT - 1)) begin
                    scnt_nx = '0;
                    if (bus.cctrans[o]) begin
                        state_nx = C2C;
                    end else if (bus.dREN[g]) begin
                        state_nx = LOAD;
                    end else begin
                        // Invalidate-only: acknowledge the requester and finish.
                        state_nx     = IDLE;
                        bus.dwait[g] = 1'b0;
                    end
                end else begin
                    scnt_nx = scnt + 1'b1;
                end
            end
            C2C: begin
                bus.ccwait[o]   = 1'b1;
                bus.ccsnoopaddr = put(base, o);
                bus.ramWEN      = 1'b1;
                bus.ramaddr     = lane(bus.daddr, o);
                bus.ramstore    = lane(bus.dstore, o);
                bus.dload       = put(lane(bus.dstore, o), g);
                bus.dwait[g]    = ~access;
                bus.dwait[o]    = ~access;
            end
            LOAD: begin
                bus.ccwait[o]   = 1'b1;
                bus.ccsnoopaddr = put(base, o);
                bus.ramREN      = 1'b1;
                bus.ramaddr     = lane(bus.daddr, g);
                bus.dload       = put(bus.ramload, g);
                bus.dwait[g]    = ~access;
            end
            IFETCH: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = lane(bus.iaddr, g);
                bus.iload    = put(bus.ramload, g);
                bus.iwait[g] = ~access;
                if (access) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Block transfers count RAM ACCESS cycles until the block is done.
        if ((state == WB || state == C2C || state == LOAD) && access) begin
            if (last_word) begin
                state_nx = IDLE;
                wcnt_nx  = '0;
            end else begin
                wcnt_nx = wcnt + 1'b1;
            end
        end
    end
endmodule
